// File: rtl/huffman_stream_encoder_if.sv
// Symbol-in / packed-word-out handshake bundle
// for the Huffman stream encoder.
interface huffman_stream_encoder_if #(
  parameter int SYM_W = 7,
  parameter int OUT_W = 8,
  parameter int LEN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_sym;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic [LEN_W:0]   out_bits;

  modport master (
    output in_valid,
    output in_sym,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_bits
  );

  modport slave (
    input  in_valid,
    input  in_sym,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_bits
  );
endinterface

// File: rtl/huffman_stream_encoder.sv
// Programmable Huffman encoder: table lookup
// plus MSB-first bit packer with flush/pad.
module huffman_stream_encoder #(
  parameter int SYM_W  = 7,
  parameter int CODE_W = 10,
  parameter int LEN_W  = 4,
  parameter int OUT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tbl_we,
  input  logic [SYM_W-1:0]  tbl_addr,
  input  logic [CODE_W-1:0] tbl_code,
  input  logic [LEN_W-1:0]  tbl_len,
  input  logic              flush,
  input  logic              err_clr,
  huffman_stream_encoder_if.slave s,
  output logic              flush_done,
  output logic              err,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int ACC_W  = OUT_W + CODE_W;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int NSYM   = 1 << SYM_W;
  localparam logic [FILL_W-1:0] OUT_F = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] ACC_F = FILL_W'(ACC_W);
  localparam logic [LEN_W-1:0]  MAX_L = LEN_W'(CODE_W);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LAST  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NSYM-1:0][LEN_W-1:0]  len_q, len_d;
  logic [NSYM-1:0][CODE_W-1:0] code_q, code_d;

  logic [LEN_W-1:0]  cur_len;
  logic [CODE_W-1:0] cur_code;
  logic [FILL_W-1:0] len_f;
  logic [FILL_W-1:0] sh;
  logic [ACC_W-1:0]  mask;
  logic [ACC_W-1:0]  code_m;
  logic [ACC_W-1:0]  app;
  logic              in_rdy;
  logic              word_ok;
  logic              accept;
  logic              pop;
  logic              bad_wr;
  logic              bad_sym;

  // Table lookup sees the registered entry (old value on a same-cycle write)
  always_comb begin
    cur_len  = len_q[s.in_sym];
    cur_code = code_q[s.in_sym];
    len_f    = FILL_W'(cur_len);
    mask     = ~({ACC_W{1'b1}} << cur_len);
    code_m   = {{OUT_W{1'b0}}, cur_code} & mask;
  end

  // Table write path; oversize lengths are dropped and flagged
  always_comb begin
    len_d  = len_q;
    code_d = code_q;
    bad_wr = 1'b0;
    if (tbl_we) begin
      if (tbl_len > MAX_L) begin
        bad_wr = 1'b1;
      end else begin
        len_d[tbl_addr]  = tbl_len;
        code_d[tbl_addr] = tbl_code;
      end
    end
  end

  // Handshake outputs, all derived from registered state
  always_comb begin
    in_rdy      = (state_q == RUN) && (fill_q <= OUT_F);
    word_ok     = (state_q != LAST) && (fill_q >= OUT_F);
    s.in_ready  = in_rdy;
    s.out_valid = word_ok || (state_q == LAST);
    s.out_data  = acc_q[ACC_W-1 -: OUT_W];
    s.out_last  = (state_q == LAST);
    if (state_q == LAST) begin
      s.out_bits = (LEN_W+1)'(fill_q);
    end else if (word_ok) begin
      s.out_bits = (LEN_W+1)'(OUT_W);
    end else begin
      s.out_bits = '0;
    end
    flush_done = ((state_q == DRAIN) && (fill_q == '0)) ||
                 ((state_q == LAST) && s.out_ready);
    accept     = s.in_valid && in_rdy;
    pop        = word_ok && s.out_ready;
    err        = err_q;
    bit_count  = cnt_q;
  end

  // Packer and flush FSM: shift out first, then append the new code
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    bad_sym = 1'b0;
    sh      = '0;
    app     = '0;

    if (pop) begin
      acc_d  = acc_q << OUT_W;
      fill_d = fill_q - OUT_F;
    end

    if (accept) begin
      if (cur_len != '0) begin
        sh     = ACC_F - fill_d - len_f;
        app    = code_m << sh;
        acc_d  = acc_d | app;
        fill_d = fill_d + len_f;
        cnt_d  = cnt_q + CNT_W'(cur_len);
      end else begin
        bad_sym = 1'b1;
      end
    end

    unique case (state_q)
      RUN: begin
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (!word_ok) begin
          if (fill_q != '0) state_d = LAST;
          else state_d = RUN;
        end
      end
      LAST: begin
        if (s.out_ready) begin
          state_d = RUN;
          fill_d  = '0;
          acc_d   = '0;
        end
      end
      default: state_d = RUN;
    endcase

    if (err_clr) err_d = 1'b0;
    if (bad_wr || bad_sym) err_d = 1'b1;
  end

  // State, accumulator, counters and code table registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      code_q  <= code_d;
    end
  end

endmodule
